// File: rtl/aes_dec_round_sched_if.sv
// Host-side block transfer bundle for the AES-128 inverse-round scheduler:
// a ciphertext handshake in and a plaintext handshake out.
interface aes_dec_round_sched_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_dec_round_sched.sv
// Iterative AES-128 decryption scheduler: owns the working state and drives a
// shared external inverse-round datapath through INIT, NR-1 ROUNDs and FINAL.
module aes_dec_round_sched #(
    parameter int NR     = 10,
    parameter int DP_LAT = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       abort,
    aes_dec_round_sched_if.slave       host,
    output logic [3:0]                 key_idx,
    output logic [1:0]                 dp_mode,
    output logic [127:0]               dp_state,
    input  logic [127:0]               dp_result,
    output logic                       busy,
    output logic [15:0]                blk_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t       state;
    logic [127:0] state_reg;
    logic [127:0] out_data_q;
    logic [3:0]   rnd;
    logic [1:0]   wcnt;
    logic         cap;

    // Capture edge: the datapath inputs have been held for DP_LAT+1 cycles.
    assign cap = (wcnt == 2'(DP_LAT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            state_reg  <= '0;
            out_data_q <= '0;
            rnd        <= '0;
            wcnt       <= '0;
            blk_count  <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            rnd   <= '0;
            wcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host.in_valid) begin
                        state_reg <= host.in_data;
                        rnd       <= 4'(NR);
                        wcnt      <= '0;
                        state     <= S_INIT;
                    end
                end
                S_INIT, S_ROUND, S_FINAL: begin
                    if (cap) begin
                        state_reg <= dp_result;
                        wcnt      <= '0;
                        if (state == S_FINAL) begin
                            out_data_q <= dp_result;
                            state      <= S_DONE;
                        end else begin
                            rnd   <= rnd - 4'd1;
                            state <= (state == S_ROUND && rnd == 4'd1) ? S_FINAL : S_ROUND;
                        end
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                S_DONE: begin
                    if (host.out_ready) begin
                        blk_count <= blk_count + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath controls are pure decodes of the registered state, so they stay
    // stable for the whole hold window of each round.
    always_comb begin
        key_idx = '0;
        dp_mode = 2'd0;
        busy    = 1'b0;
        case (state)
            S_INIT:  begin dp_mode = 2'd1; key_idx = rnd; busy = 1'b1; end
            S_ROUND: begin dp_mode = 2'd2; key_idx = rnd; busy = 1'b1; end
            S_FINAL: begin dp_mode = 2'd3; key_idx = rnd; busy = 1'b1; end
            default: ;
        endcase
    end

    assign dp_state       = state_reg;
    assign host.in_ready  = (state == S_IDLE);
    assign host.out_valid = (state == S_DONE);
    assign host.out_data  = out_data_q;

endmodule

// File: tb/tb_aes_dec_round_sched.sv
// Bench for aes_dec_round_sched: two instances (DP_LAT 0 and 2) share a host port
// selected by sel; key store and inverse datapath are modelled here from FIPS-197.
module tb_aes_dec_round_sched;
    localparam int NR = 10;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0;
    logic reset, abort, sel, in_valid, out_ready;
    logic [127:0] in_data;
    int tests = 0;
    int fails = 0;
    logic [15:0] exp_cnt [2];

    always #5 clk = ~clk;

    aes_dec_round_sched_if h0();
    aes_dec_round_sched_if h1();
    assign h0.in_valid  = in_valid & ~sel;
    assign h1.in_valid  = in_valid & sel;
    assign h0.in_data   = in_data;
    assign h1.in_data   = in_data;
    assign h0.out_ready = out_ready & ~sel;
    assign h1.out_ready = out_ready & sel;

    logic [3:0] k0, k1;
    logic [1:0] m0, m1;
    logic [127:0] s0, s1, r0, r1, p1, p2;
    logic b0, b1;
    logic [15:0] c0, c1;

    aes_dec_round_sched #(.NR(NR), .DP_LAT(0)) u0 (
        .clk(clk), .reset(reset), .abort(abort), .host(h0),
        .key_idx(k0), .dp_mode(m0), .dp_state(s0), .dp_result(r0),
        .busy(b0), .blk_count(c0));

    aes_dec_round_sched #(.NR(NR), .DP_LAT(2)) u1 (
        .clk(clk), .reset(reset), .abort(abort), .host(h1),
        .key_idx(k1), .dp_mode(m1), .dp_state(s1), .dp_result(r1),
        .busy(b1), .blk_count(c1));

    logic o_in_ready, o_out_valid, o_busy;
    logic [127:0] o_out_data, o_dp_state;
    logic [3:0] o_key;
    logic [1:0] o_mode;
    logic [15:0] o_cnt;
    assign o_in_ready  = sel ? h1.in_ready  : h0.in_ready;
    assign o_out_valid = sel ? h1.out_valid : h0.out_valid;
    assign o_out_data  = sel ? h1.out_data  : h0.out_data;
    assign o_dp_state  = sel ? s1 : s0;
    assign o_key       = sel ? k1 : k0;
    assign o_mode      = sel ? m1 : m0;
    assign o_busy      = sel ? b1 : b0;
    assign o_cnt       = sel ? c1 : c0;

    // ---------------- AES reference model ----------------
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [16];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isbox[gb(s, i)] : sbox[gb(s, i)];
        return o;
    endfunction

    // byte index = row + 4*column
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (inv) o[127-8*(r+4*((c+r)%4)) -: 8] = gb(s, r + 4*c);
                else     o[127-8*(r+4*c) -: 8]         = gb(s, r + 4*((c+r)%4));
            end
        return o;
    endfunction

    function automatic logic [7:0] mcoef(input int k, input bit inv);
        case (k)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0] acc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(mcoef((j - r + 4) % 4, inv), gb(s, j + 4*c));
                o[127-8*(r+4*c) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < NR; r++)
            s = mix_cols(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
        return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[NR];
    endfunction

    function automatic logic [127:0] dp_fn(input logic [1:0] mode, input logic [127:0] s,
                                           input logic [127:0] k);
        case (mode)
            2'd1:    return sub_bytes(shift_rows(s ^ k, 1'b1), 1'b1);
            2'd2:    return sub_bytes(shift_rows(mix_cols(s ^ k, 1'b1), 1'b1), 1'b1);
            2'd3:    return s ^ k;
            default: return 'x;
        endcase
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // External datapaths: combinational for u0, two register stages for u1.
    always_comb r0 = dp_fn(m0, s0, rk[k0]);
    always @(posedge clk) begin
        p1 <= dp_fn(m1, s1, rk[k1]);
        p2 <= p1;
    end
    assign r1 = p2;

    task automatic build_model();
        logic [7:0] inv, b;
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rcon;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x] = b;
            isbox[b] = 8'(x);
        end
        for (int i = 0; i < 4; i++) w[i] = FIPS_KEY[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // ---------------- host-side helpers ----------------
    task automatic accept(input logic [127:0] ct);
        in_data  = ct;
        in_valid = 1'b1;
        tests++;
        if (o_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_ready: got %b expected 1", o_in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rnd128();
    endtask

    task automatic collect(input logic [127:0] exp_pt, input int lat, input string nm);
        int n, bad, per, total, g;
        per = lat + 1;
        total = (NR + 1) * per;
        n = 0;
        bad = 0;
        while (o_out_valid !== 1'b1 && n < total + 20) begin
            g = n / per;
            if (n >= total || o_key !== 4'(NR - g) || o_busy !== 1'b1 ||
                o_mode !== ((g == 0) ? 2'd1 : (g == NR) ? 2'd3 : 2'd2)) bad++;
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n != total) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles expected %0d", nm, n, total);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s key_trace: got %0d bad cycles expected 0", nm, bad);
        end
        tests++;
        if (o_out_data !== exp_pt) begin
            fails++;
            $display("FAIL %s plaintext: got %h expected %h", nm, o_out_data, exp_pt);
        end
        tests++;
        if (o_key !== 4'd0 || o_mode !== 2'd0 || o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s done_outputs: got key=%0d mode=%0d busy=%b rdy=%b expected 0 0 0 0",
                     nm, o_key, o_mode, o_busy, o_in_ready);
        end
    endtask

    task automatic finish_block(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt[sel] = exp_cnt[sel] + 16'd1;
        tests++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s handshake: got valid=%b ready=%b expected 0 1", nm, o_out_valid, o_in_ready);
        end
        tests++;
        if (o_cnt !== exp_cnt[sel]) begin
            fails++;
            $display("FAIL %s blk_count: got %h expected %h", nm, o_cnt, exp_cnt[sel]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        #12;
        tests++;
        if (o_out_valid !== 0 || o_busy !== 0 || o_key !== 0 || o_mode !== 0) begin
            fails++;
            $display("FAIL reset_ctrl: got valid=%b busy=%b key=%0d mode=%0d expected 0", o_out_valid, o_busy, o_key, o_mode);
        end
        tests++;
        if (o_out_data !== 128'h0 || o_dp_state !== 128'h0) begin
            fails++;
            $display("FAIL reset_data: got out=%h st=%h expected 0", o_out_data, o_dp_state);
        end
        tests++;
        if (c0 !== 16'h0 || c1 !== 16'h0) begin
            fails++;
            $display("FAIL reset_count: got %h %h expected 0000", c0, c1);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (h0.in_ready !== 1'b1 || h1.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b %b expected 1 1", h0.in_ready, h1.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fips_lat0();
        sel = 1'b0;
        accept(FIPS_CT);
        collect(FIPS_PT, 0, "fips_lat0");
        finish_block("fips_lat0");
    endtask

    task automatic test_fips_lat2();
        sel = 1'b1;
        accept(FIPS_CT);
        collect(FIPS_PT, 2, "fips_lat2");
        finish_block("fips_lat2");
        sel = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] pt;
        for (int i = 0; i < 6; i++) begin
            sel = (i % 3 == 2);
            pt = rnd128();
            accept(encrypt(pt));
            collect(pt, sel ? 2 : 0, "random");
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            finish_block("random");
        end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt1, pt2;
        int bad;
        sel = 1'b0;
        pt1 = rnd128();
        pt2 = rnd128();
        accept(encrypt(pt1));
        collect(pt1, 0, "bp_first");
        in_data  = encrypt(pt2);
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_out_valid !== 1'b1 || o_out_data !== pt1 || o_in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: got %0d bad cycles expected 0", bad);
        end
        finish_block("bp_release");
        accept(encrypt(pt2));
        collect(pt2, 0, "bp_second");
        finish_block("bp_second");
    endtask

    task automatic test_abort();
        logic [127:0] pt;
        int n;
        logic seen;
        sel = 1'b0;
        pt = rnd128();
        accept(encrypt(pt));
        n = 0;
        while (o_key !== 4'd5 && n < 40) begin @(posedge clk); #1; n++; end
        tests++;
        if (o_key !== 4'd5 || o_mode !== 2'd2) begin
            fails++;
            $display("FAIL abort_reach_k5: got key=%0d mode=%0d expected 5 2", o_key, o_mode);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tests++;
        if (o_busy !== 0 || o_in_ready !== 1 || o_key !== 0 || o_mode !== 0) begin
            fails++;
            $display("FAIL abort_idle: got busy=%b rdy=%b key=%0d mode=%0d expected 0 1 0 0", o_busy, o_in_ready, o_key, o_mode);
        end
        seen = 1'b0;
        repeat (15) begin seen |= o_out_valid; @(posedge clk); #1; end
        tests++;
        if (seen !== 1'b0 || o_cnt !== exp_cnt[0]) begin
            fails++;
            $display("FAIL abort_no_output: got valid_seen=%b cnt=%h expected 0 %h", seen, o_cnt, exp_cnt[0]);
        end
        in_valid = 1'b1;
        in_data  = encrypt(pt);
        abort    = 1'b1;
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (o_busy !== 1'b0 || o_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_wins: got busy=%b rdy=%b expected 0 1", o_busy, o_in_ready);
        end
        accept(encrypt(pt));
        collect(pt, 0, "abort_done");
        abort = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_cnt !== exp_cnt[0]) begin
            fails++;
            $display("FAIL abort_in_done: got valid=%b rdy=%b cnt=%h expected 0 1 %h", o_out_valid, o_in_ready, o_cnt, exp_cnt[0]);
        end
        pt = rnd128();
        accept(encrypt(pt));
        collect(pt, 0, "after_abort");
        finish_block("after_abort");
    endtask

    task automatic test_async_reset();
        logic [127:0] pt;
        sel = 1'b0;
        pt = rnd128();
        accept(encrypt(pt));
        repeat (4) begin @(posedge clk); #1; end
        tests++;
        if (o_busy !== 1'b1 || o_mode !== 2'd2) begin
            fails++;
            $display("FAIL areset_pre: got busy=%b mode=%0d expected 1 2", o_busy, o_mode);
        end
        #2;
        reset = 1'b0;
        #1;
        exp_cnt[0] = 16'h0;
        exp_cnt[1] = 16'h0;
        tests++;
        if (o_busy !== 0 || o_key !== 0 || o_mode !== 0 || o_out_valid !== 0 || o_cnt !== 0) begin
            fails++;
            $display("FAIL areset_ctrl: got busy=%b key=%0d mode=%0d valid=%b cnt=%h expected 0", o_busy, o_key, o_mode, o_out_valid, o_cnt);
        end
        tests++;
        if (o_out_data !== 128'h0 || o_dp_state !== 128'h0) begin
            fails++;
            $display("FAIL areset_data: got out=%h st=%h expected 0", o_out_data, o_dp_state);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (o_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL areset_release: got in_ready=%b expected 1", o_in_ready);
        end
        @(posedge clk); #1;
        accept(FIPS_CT);
        collect(FIPS_PT, 0, "after_reset");
        finish_block("after_reset");
    endtask

    task automatic test_counter_wrap();
        sel = 1'b0;
        accept(FIPS_CT);
        collect(FIPS_PT, 0, "wrap");
        force u0.blk_count = 16'hffff;
        #1;
        release u0.blk_count;
        exp_cnt[0] = 16'hffff;
        finish_block("wrap");
    endtask

    initial begin
        reset = 1'b0; abort = 1'b0; sel = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        exp_cnt[0] = 16'h0;
        exp_cnt[1] = 16'h0;
        build_model();
        test_reset();
        test_fips_lat0();
        test_fips_lat2();
        test_random();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
